cpu_run_ctrl: RTL and testbench

- Synthesizable run controller that sits between the top-level harness and the pipelined MIPS CPU core.
- Generates the CPU reset window and drives the forwarding-enable vector per forwarding path.
- Detects end-of-program, enforces a cycle timeout and collects cycles, retired-instruction and stall statistics.
- Optional sweep mode runs the same program twice: forwarding forced off, then the requested forwarding mask. Results of both runs are kept.

---
 rtl/cpu_run_pkg.sv | 20 ++
 rtl/sat_counter.sv | 36 +++
 rtl/cpu_run_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// Shared types and constants for the CPU run controller.
package cpu_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4,
        ST_TIMEOUT = 3'd5
    } run_state_e;

    // Bit positions inside the forwarding-enable vector.
    localparam int unsigned FWD_EX_EX  = 0;
    localparam int unsigned FWD_MEM_EX = 1;

    localparam int unsigned DEF_RST_CYCLES   = 10;
    localparam int unsigned DEF_DRAIN_CYCLES = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear, else increment unless already at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: CPU reset window, forwarding enables, halt/drain/timeout
// detection, run statistics and an optional forwarding-off/on sweep.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
    parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int unsigned MAX_CYCLES   = 65535,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned FWD_W        = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sweep,
    input  logic [FWD_W-1:0] fwd_mask,
    input  logic             halt_i,
    input  logic             retire_i,
    input  logic             stall_i,
    output logic             cpu_rst,
    output logic [FWD_W-1:0] forwarding_EN,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] base_cycle_cnt
);

    localparam int unsigned TMR_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_CYCLES - 1);
    localparam logic [63:0]      TMO_AT     = 64'(MAX_CYCLES);

    run_state_e       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             pass_q, pass_d;
    logic             sweep_q, sweep_d;
    logic [FWD_W-1:0] mask_q, mask_d;

    logic             cpu_rst_q;
    logic [FWD_W-1:0] fwd_q;
    logic             busy_q, done_q, timeout_q;
    logic [CNT_W-1:0] base_q;

    logic             counting_c, cyc_sat_c, tmo_hit_c;
    logic             start_acc_c, base_ld_c, cnt_clr_c;
    logic [CNT_W-1:0] cyc_nxt_c;

    // Counting window and the edge on which the cycle count reaches the limit.
    always_comb begin
        counting_c = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        cyc_sat_c  = &cycle_cnt;
        cyc_nxt_c  = cyc_sat_c ? cycle_cnt : cycle_cnt + CNT_W'(1);
        tmo_hit_c  = counting_c && !cyc_sat_c && ((64'(cycle_cnt) + 64'd1) == TMO_AT);
    end

    // FSM state and run-context registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            pass_q  <= 1'b0;
            sweep_q <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            pass_q  <= pass_d;
            sweep_q <= sweep_d;
            mask_q  <= mask_d;
        end
    end

    // Next-state logic; timeout outranks halt and drain completion.
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        pass_d      = pass_q;
        sweep_d     = sweep_q;
        mask_d      = mask_q;
        start_acc_c = 1'b0;
        base_ld_c   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start) begin
                    start_acc_c = 1'b1;
                    sweep_d     = sweep;
                    mask_d      = fwd_mask;
                    pass_d      = 1'b0;
                    tmr_d       = '0;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr_q == HOLD_LAST) begin
                    tmr_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_RUN: begin
                if (tmo_hit_c) begin
                    state_d = ST_TIMEOUT;
                end else if (halt_i) begin
                    tmr_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (tmo_hit_c) begin
                    state_d = ST_TIMEOUT;
                end else if (tmr_q == DRAIN_LAST) begin
                    tmr_d = '0;
                    if (sweep_q && !pass_q) begin
                        base_ld_c = 1'b1;
                        pass_d    = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cnt_clr_c = start_acc_c || base_ld_c;
    end

    // Registered outputs derived from the current state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cpu_rst_q <= 1'b1;
            fwd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cpu_rst_q <= !counting_c;
            busy_q    <= (state_q == ST_HOLD) || counting_c;
            done_q    <= (state_q == ST_DONE);
            timeout_q <= (state_q == ST_TIMEOUT);
            if (state_q == ST_HOLD) begin
                fwd_q <= (sweep_q && !pass_q) ? '0 : mask_q;
            end
        end
    end

    // Forwarding-off run length, captured when pass 0 hands over to pass 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            base_q <= '0;
        end else if (base_ld_c) begin
            base_q <= cyc_nxt_c;
        end else if (start_acc_c) begin
            base_q <= '0;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (cnt_clr_c),
        .inc_i (counting_c),
        .cnt_o (cycle_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (cnt_clr_c),
        .inc_i (counting_c && retire_i),
        .cnt_o (retire_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (cnt_clr_c),
        .inc_i (counting_c && stall_i),
        .cnt_o (stall_cnt)
    );

    assign cpu_rst        = cpu_rst_q;
    assign forwarding_EN  = fwd_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign timeout        = timeout_q;
    assign base_cycle_cnt = base_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: three configurations share one stimulus stream
// (defaults / MAX_CYCLES=100 / CNT_W=4) and are compared every cycle
// against a phase-level reference model, plus directed literal checks.
module tb_cpu_run_ctrl;

    localparam int P_IDLE = 0, P_HOLD = 1, P_RUN = 2, P_DRAIN = 3, P_DONE = 4, P_TMO = 5;
    localparam int RSTC = 10;
    localparam int DRNC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0, start = 1'b0, sweep = 1'b0;
    logic       halt_i = 1'b0, retire_i = 1'b0, stall_i = 1'b0;
    logic [1:0] fwd_mask = 2'b00;
    bit         toggle_en = 1'b0;

    logic        a_cpu_rst, a_busy, a_done, a_tmo;
    logic [1:0]  a_fwd;
    logic [31:0] a_cyc, a_ret, a_stl, a_base;
    logic        b_cpu_rst, b_busy, b_done, b_tmo;
    logic [1:0]  b_fwd;
    logic [31:0] b_cyc, b_ret, b_stl, b_base;
    logic        c_cpu_rst, c_busy, c_done, c_tmo;
    logic [1:0]  c_fwd;
    logic [3:0]  c_cyc, c_ret, c_stl, c_base;

    cpu_run_ctrl u_a (
        .clk(clk), .rst(rst), .start(start), .sweep(sweep), .fwd_mask(fwd_mask),
        .halt_i(halt_i), .retire_i(retire_i), .stall_i(stall_i),
        .cpu_rst(a_cpu_rst), .forwarding_EN(a_fwd), .busy(a_busy), .done(a_done),
        .timeout(a_tmo), .cycle_cnt(a_cyc), .retire_cnt(a_ret), .stall_cnt(a_stl),
        .base_cycle_cnt(a_base)
    );

    cpu_run_ctrl #(.MAX_CYCLES(100)) u_b (
        .clk(clk), .rst(rst), .start(start), .sweep(sweep), .fwd_mask(fwd_mask),
        .halt_i(halt_i), .retire_i(retire_i), .stall_i(stall_i),
        .cpu_rst(b_cpu_rst), .forwarding_EN(b_fwd), .busy(b_busy), .done(b_done),
        .timeout(b_tmo), .cycle_cnt(b_cyc), .retire_cnt(b_ret), .stall_cnt(b_stl),
        .base_cycle_cnt(b_base)
    );

    cpu_run_ctrl #(.CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .start(start), .sweep(sweep), .fwd_mask(fwd_mask),
        .halt_i(halt_i), .retire_i(retire_i), .stall_i(stall_i),
        .cpu_rst(c_cpu_rst), .forwarding_EN(c_fwd), .busy(c_busy), .done(c_done),
        .timeout(c_tmo), .cycle_cnt(c_cyc), .retire_cnt(c_ret), .stall_cnt(c_stl),
        .base_cycle_cnt(c_base)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int idx, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] actual %0d expected %0d t=%0t", nm, idx, act, exp, $time);
        end
    endtask

    // Reference model: one phase per instance, counters as plain saturating integers.
    longint MAXC [3] = '{65535, 100, 65535};
    longint LIM  [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 15};
    int     ph [3], left [3], pass [3];
    bit     msw [3];
    logic [1:0] mmask [3];
    longint cyc [3], ret [3], stl [3], base [3];
    bit     e_rst [3], e_busy [3], e_done [3], e_tmo [3];
    logic [1:0] e_fwd [3];
    bit     valid = 1'b0;

    function automatic longint sat_inc(input longint v, input longint lim);
        return (v < lim) ? v + 1 : v;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                ph[i] = P_IDLE; left[i] = 0; pass[i] = 0; msw[i] = 0; mmask[i] = 2'b00;
                cyc[i] = 0; ret[i] = 0; stl[i] = 0; base[i] = 0;
                e_rst[i] = 1; e_busy[i] = 0; e_done[i] = 0; e_tmo[i] = 0; e_fwd[i] = 2'b00;
            end else begin
                e_rst[i]  = !(ph[i] == P_RUN || ph[i] == P_DRAIN);
                e_busy[i] = (ph[i] == P_HOLD || ph[i] == P_RUN || ph[i] == P_DRAIN);
                e_done[i] = (ph[i] == P_DONE);
                e_tmo[i]  = (ph[i] == P_TMO);
                if (ph[i] == P_HOLD) e_fwd[i] = (msw[i] && pass[i] == 0) ? 2'b00 : mmask[i];
                case (ph[i])
                    P_IDLE, P_DONE, P_TMO: begin
                        if (start) begin
                            msw[i] = sweep; mmask[i] = fwd_mask; pass[i] = 0;
                            cyc[i] = 0; ret[i] = 0; stl[i] = 0; base[i] = 0;
                            ph[i] = P_HOLD; left[i] = RSTC;
                        end
                    end
                    P_HOLD: begin
                        left[i]--;
                        if (left[i] == 0) ph[i] = P_RUN;
                    end
                    default: begin
                        cyc[i] = sat_inc(cyc[i], LIM[i]);
                        if (retire_i) ret[i] = sat_inc(ret[i], LIM[i]);
                        if (stall_i)  stl[i] = sat_inc(stl[i], LIM[i]);
                        if (cyc[i] == MAXC[i]) begin
                            ph[i] = P_TMO;
                        end else if (ph[i] == P_RUN) begin
                            if (halt_i) begin ph[i] = P_DRAIN; left[i] = DRNC; end
                        end else begin
                            left[i]--;
                            if (left[i] == 0) begin
                                if (msw[i] && pass[i] == 0) begin
                                    base[i] = cyc[i]; cyc[i] = 0; ret[i] = 0; stl[i] = 0;
                                    pass[i] = 1; ph[i] = P_HOLD; left[i] = RSTC;
                                end else begin
                                    ph[i] = P_DONE;
                                end
                            end
                        end
                    end
                endcase
            end
        end
        if (!rst) valid = 1'b1;
    end

    task automatic cmp_inst(input int i, input logic r, input logic [1:0] f, input logic b,
                            input logic d, input logic t, input longint cy, input longint re,
                            input longint st, input longint ba);
        chk("cpu_rst", i, longint'(r), longint'(e_rst[i]));
        chk("forwarding_EN", i, longint'(f), longint'(e_fwd[i]));
        chk("busy", i, longint'(b), longint'(e_busy[i]));
        chk("done", i, longint'(d), longint'(e_done[i]));
        chk("timeout", i, longint'(t), longint'(e_tmo[i]));
        chk("cycle_cnt", i, cy, cyc[i]);
        chk("retire_cnt", i, re, ret[i]);
        chk("stall_cnt", i, st, stl[i]);
        chk("base_cycle_cnt", i, ba, base[i]);
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (valid) begin
            cmp_inst(0, a_cpu_rst, a_fwd, a_busy, a_done, a_tmo,
                     longint'(a_cyc), longint'(a_ret), longint'(a_stl), longint'(a_base));
            cmp_inst(1, b_cpu_rst, b_fwd, b_busy, b_done, b_tmo,
                     longint'(b_cyc), longint'(b_ret), longint'(b_stl), longint'(b_base));
            cmp_inst(2, c_cpu_rst, c_fwd, c_busy, c_done, c_tmo,
                     longint'(c_cyc), longint'(c_ret), longint'(c_stl), longint'(c_base));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_en) begin
            retire_i = ~retire_i;
            stall_i  = ~retire_i;
        end
    endtask

    task automatic pulse_start(input logic sw, input logic [1:0] m);
        start = 1'b1; sweep = sw; fwd_mask = m;
        tick();
        start = 1'b0;
    endtask

    // Raise halt for one cycle once instance A has counted n cycles.
    task automatic halt_at(input longint n);
        int k = 0;
        while (longint'(a_cyc) != n && k < 2000) begin tick(); k++; end
        chk("halt_wait", 0, longint'(k < 2000), 1);
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
    endtask

    task automatic wait_a_done();
        int k = 0;
        while (!a_done && k < 500) begin tick(); k++; end
        chk("done_wait", 0, longint'(k < 500), 1);
    endtask

    task automatic wait_b_tmo();
        int k = 0;
        while (!b_tmo && k < 500) begin tick(); k++; end
        chk("timeout_wait", 1, longint'(k < 500), 1);
    endtask

    initial begin
        int     n;
        int     k;
        longint v;

        repeat (3) tick();
        chk("rst_cpu_rst", 0, longint'(a_cpu_rst), 1);
        chk("rst_cycle_cnt", 0, longint'(a_cyc), 0);
        chk("rst_busy", 0, longint'(a_busy), 0);
        rst = 1'b1;
        tick();

        // Single run, both forwarding paths, halt after 50 run cycles.
        pulse_start(1'b0, 2'b11);
        n = 0;
        while (n < 100) begin
            tick();
            if (a_cpu_rst) n++; else break;
        end
        chk("hold_len", 0, n, 10);
        chk("fwd_run", 0, longint'(a_fwd), 3);
        halt_at(50);
        wait_a_done();
        chk("cycle_cnt_single", 0, longint'(a_cyc), 55);
        chk("done_single", 0, longint'(a_done), 1);
        chk("cnt4_saturated", 2, longint'(c_cyc), 15);

        // Sweep: 80 cycles without forwarding, 60 with.
        pulse_start(1'b1, 2'b11);
        halt_at(80);
        chk("fwd_pass0", 0, longint'(a_fwd), 0);
        k = 0;
        while (!a_cpu_rst && k < 100) begin tick(); k++; end
        n = 0;
        while (a_cpu_rst && n < 100) begin n++; tick(); end
        chk("hold_len_pass1", 0, n, 10);
        halt_at(60);
        chk("fwd_pass1", 0, longint'(a_fwd), 3);
        wait_a_done();
        chk("base_cycle_cnt", 0, longint'(a_base), 85);
        chk("cycle_cnt_pass1", 0, longint'(a_cyc), 65);
        chk("done_sweep", 0, longint'(a_done), 1);

        // Alternating retire/stall over 40 counted cycles.
        retire_i = 1'b0; stall_i = 1'b1; toggle_en = 1'b1;
        pulse_start(1'b0, 2'b01);
        halt_at(35);
        wait_a_done();
        toggle_en = 1'b0; retire_i = 1'b0; stall_i = 1'b0;
        chk("retire_cnt", 0, longint'(a_ret), 20);
        chk("stall_cnt", 0, longint'(a_stl), 20);
        chk("cnt4_retire_sat", 2, longint'(c_ret), 15);

        // No halt: instance B times out at 100 cycles.
        pulse_start(1'b0, 2'b10);
        wait_b_tmo();
        chk("timeout_lvl", 1, longint'(b_tmo), 1);
        chk("timeout_done", 1, longint'(b_done), 0);
        chk("timeout_cyc", 1, longint'(b_cyc), 100);
        chk("timeout_cpu_rst", 1, longint'(b_cpu_rst), 1);

        // start while A is running is ignored.
        v = longint'(a_cyc);
        pulse_start(1'b1, 2'b00);
        chk("start_ignored", 0, longint'(a_cyc), v + 1);

        // Reset mid-run.
        rst = 1'b0;
        tick();
        chk("midrst_cyc", 0, longint'(a_cyc), 0);
        chk("midrst_busy", 0, longint'(a_busy), 0);
        chk("midrst_cpu_rst", 0, longint'(a_cpu_rst), 1);
        chk("midrst_fwd", 0, longint'(a_fwd), 0);
        rst = 1'b1;
        tick();

        // halt on the edge the count reaches the limit: timeout wins.
        pulse_start(1'b0, 2'b11);
        k = 0;
        while (b_cyc != 32'd99 && k < 500) begin tick(); k++; end
        chk("cyc99_wait", 1, longint'(k < 500), 1);
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        wait_b_tmo();
        chk("tmo_vs_halt_tmo", 1, longint'(b_tmo), 1);
        chk("tmo_vs_halt_done", 1, longint'(b_done), 0);
        chk("tmo_vs_halt_cyc", 1, longint'(b_cyc), 100);

        // Randomized traffic.
        for (int t = 0; t < 3000; t++) begin
            rst      = ($urandom_range(0, 499) != 0);
            start    = ($urandom_range(0, 39) == 0);
            sweep    = 1'($urandom_range(0, 1));
            fwd_mask = 2'($urandom_range(0, 3));
            halt_i   = ($urandom_range(0, 29) == 0);
            retire_i = 1'($urandom_range(0, 1));
            stall_i  = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0; halt_i = 1'b0; rst = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
